// File: rtl/seg7_reader.sv
// seg7_reader: loopback monitor that syncs, stability-filters and decodes an active-low 7-segment bus.
// Latency: an accepted pattern appears STABLE_CYCLES+2 edges after SEG_IN settles (2 sync + filter).
// Backpressure: none; the bus is sampled every edge, and patterns that are not stable long enough are dropped.
module seg7_reader #(
  parameter int STABLE_CYCLES = 3,  // legal range 2..15
  parameter int CNT_W         = 8
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  input  logic [0:6]       SEG_IN,      // active-low, index 0 = a ... 6 = g
  input  logic             CLR,
  output logic [3:0]       DIGIT,
  output logic             DIGIT_VALID,
  output logic             BLANK,
  output logic             INVALID,
  output logic             UPDATE,
  output logic [CNT_W-1:0] UPD_COUNT,
  output logic [CNT_W-1:0] ERR_COUNT
);

  // Internal patterns are [6:0] with segment a in the MSB. A positional copy
  // of SEG_IN keeps the written a..g literal order identical to the port's.
  localparam logic [6:0]       LP_BLANK  = 7'b1111111;
  localparam logic [3:0]       LP_STABLE = 4'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] LP_MAX    = '1;

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_LOCKED   = 2'd1,
    ST_SETTLING = 2'd2
  } state_t;

  logic [6:0]       w_seg_in;
  logic [6:0]       r_sync1;
  logic [6:0]       r_sync2;
  logic [1:0]       r_sync_fill;
  logic             w_sync_ok;
  logic [6:0]       r_cand;
  logic [6:0]       r_acc;
  logic [3:0]       r_stab_cnt;
  state_t           r_state;
  logic             w_new;
  logic             w_accept;
  logic [3:0]       w_dec_digit;
  logic             w_dec_valid;
  logic             w_dec_blank;
  logic             w_dec_inv;
  logic [3:0]       r_digit;
  logic             r_digit_valid;
  logic             r_blank;
  logic             r_invalid;
  logic             r_update;
  logic [CNT_W-1:0] r_upd_count;
  logic [CNT_W-1:0] r_err_count;

  assign w_seg_in = SEG_IN;

  // Two-flop synchroniser for the asynchronous segment bus
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_sync1 <= LP_BLANK;
      r_sync2 <= LP_BLANK;
    end else begin
      r_sync1 <= w_seg_in;
      r_sync2 <= r_sync1;
    end
  end

  // sync2 only holds a real sample of SEG_IN two edges after reset release;
  // until then it holds the reset value, which must not count towards stability.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_sync_fill <= 2'd0;
    end else if (!r_sync_fill[1]) begin
      r_sync_fill <= r_sync_fill + 2'd1;
    end
  end

  assign w_sync_ok = r_sync_fill[1];
  assign w_new     = (r_sync2 != r_cand);

  // Accept fires on the edge where the run of identical samples reaches
  // STABLE_CYCLES, and only if it brings something new (or nothing is held yet)
  assign w_accept = w_sync_ok && !w_new
                 && (r_stab_cnt < LP_STABLE)
                 && ((r_stab_cnt + 4'd1) == LP_STABLE)
                 && ((r_state == ST_EMPTY) || (r_cand != r_acc));

  // Decode the current candidate; consumed only on the accept edge
  always_comb begin
    w_dec_digit = 4'd0;
    w_dec_valid = 1'b1;
    w_dec_blank = 1'b0;
    case (r_cand)
      7'b0000001: w_dec_digit = 4'd0;
      7'b1001111: w_dec_digit = 4'd1;
      7'b0010010: w_dec_digit = 4'd2;
      7'b0000110: w_dec_digit = 4'd3;
      7'b1001100: w_dec_digit = 4'd4;
      7'b0100100: w_dec_digit = 4'd5;
      7'b0100000: w_dec_digit = 4'd6;
      7'b0001111: w_dec_digit = 4'd7;
      7'b0000000: w_dec_digit = 4'd8;
      7'b0000100: w_dec_digit = 4'd9;
      LP_BLANK: begin
        w_dec_valid = 1'b0;
        w_dec_blank = 1'b1;
      end
      default: w_dec_valid = 1'b0;
    endcase
  end

  assign w_dec_inv = !w_dec_valid && !w_dec_blank;

  // Stability filter, EMPTY/LOCKED/SETTLING state machine and registered decode outputs
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_cand        <= LP_BLANK;
      r_acc         <= LP_BLANK;
      r_stab_cnt    <= 4'd0;
      r_state       <= ST_EMPTY;
      r_digit       <= 4'd0;
      r_digit_valid <= 1'b0;
      r_blank       <= 1'b0;
      r_invalid     <= 1'b0;
      r_update      <= 1'b0;
    end else begin
      r_update <= w_accept;
      if (w_sync_ok) begin
        if (w_new) begin
          r_cand     <= r_sync2;
          r_stab_cnt <= 4'd1;
          case (r_state)
            ST_LOCKED:   if (r_sync2 != r_acc) r_state <= ST_SETTLING;
            // Bouncing back to the held pattern before acceptance is silent
            ST_SETTLING: if (r_sync2 == r_acc) r_state <= ST_LOCKED;
            default:     ;
          endcase
        end else if (r_stab_cnt < LP_STABLE) begin
          r_stab_cnt <= r_stab_cnt + 4'd1;
          if (w_accept) begin
            r_acc         <= r_cand;
            r_state       <= ST_LOCKED;
            r_digit_valid <= w_dec_valid;
            r_blank       <= w_dec_blank;
            r_invalid     <= w_dec_inv;
            // DIGIT keeps the last real digit across blank/invalid patterns
            if (w_dec_valid) r_digit <= w_dec_digit;
          end
        end
      end
    end
  end

  // Saturating update/error counters; CLR overrides a coincident increment
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_upd_count <= '0;
      r_err_count <= '0;
    end else if (CLR) begin
      r_upd_count <= '0;
      r_err_count <= '0;
    end else begin
      if (w_accept && (r_upd_count != LP_MAX)) r_upd_count <= r_upd_count + 1'b1;
      if (w_accept && w_dec_inv && (r_err_count != LP_MAX)) r_err_count <= r_err_count + 1'b1;
    end
  end

  assign DIGIT       = r_digit;
  assign DIGIT_VALID = r_digit_valid;
  assign BLANK       = r_blank;
  assign INVALID     = r_invalid;
  assign UPDATE      = r_update;
  assign UPD_COUNT   = r_upd_count;
  assign ERR_COUNT   = r_err_count;

endmodule

// File: tb/tb_seg7_reader.sv
// tb_seg7_reader: scoreboard bench for seg7_reader.
// Latency: every UPDATE is checked to land STABLE_CYCLES+2 edges after its stimulus.
// Backpressure: none; stimulus pushes expectations, a negedge monitor pops them on UPDATE.
module tb_seg7_reader;

  localparam int STB  = 3;
  localparam int CW   = 8;
  localparam int MAXC = (1 << CW) - 1;

  logic          CLOCK_50;
  logic          RESET_N;
  logic [0:6]    SEG_IN;
  logic          CLR;
  logic [3:0]    DIGIT;
  logic          DIGIT_VALID;
  logic          BLANK;
  logic          INVALID;
  logic          UPDATE;
  logic [CW-1:0] UPD_COUNT;
  logic [CW-1:0] ERR_COUNT;

  seg7_reader #(.STABLE_CYCLES(STB), .CNT_W(CW)) dut (
    .CLOCK_50    (CLOCK_50),
    .RESET_N     (RESET_N),
    .SEG_IN      (SEG_IN),
    .CLR         (CLR),
    .DIGIT       (DIGIT),
    .DIGIT_VALID (DIGIT_VALID),
    .BLANK       (BLANK),
    .INVALID     (INVALID),
    .UPDATE      (UPDATE),
    .UPD_COUNT   (UPD_COUNT),
    .ERR_COUNT   (ERR_COUNT)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  typedef struct {
    int digit;
    bit dv;
    bit bl;
    bit inv;
    int upd;
    int err;
    int cyc;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  bit         m_empty;
  logic [6:0] m_acc;
  int         m_digit;
  int         m_upd;
  int         m_err;

  logic [6:0] codes [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                             7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

  function automatic int lookup(input logic [6:0] p);
    int r = -1;
    for (int i = 0; i < 10; i++) if (codes[i] == p) r = i;
    return r;
  endfunction

  task automatic model_reset();
    m_empty = 1'b1;
    m_acc   = 7'b1111111;
    m_digit = 0;
    m_upd   = 0;
    m_err   = 0;
  endtask

  // Drive p from just after an edge, hold it for 'hold' edges; CLR is high
  // during edge clr_at (0 = never). Pushes an expectation if the model accepts.
  task automatic drive_pat(input logic [6:0] p, input int hold, input int clr_at);
    exp_t e;
    int   d;
    SEG_IN = p;
    if ((hold >= STB) && (m_empty || (p != m_acc))) begin
      m_empty = 1'b0;
      m_acc   = p;
      d       = lookup(p);
      e.dv = 1'b0; e.bl = 1'b0; e.inv = 1'b0;
      if (d >= 0) begin
        m_digit = d;
        e.dv    = 1'b1;
      end else if (p == 7'b1111111) begin
        e.bl = 1'b1;
      end else begin
        e.inv = 1'b1;
        if (m_err < MAXC) m_err++;
      end
      if (m_upd < MAXC) m_upd++;
      if (clr_at == STB + 2) begin
        m_upd = 0;
        m_err = 0;
      end
      e.digit = m_digit;
      e.upd   = m_upd;
      e.err   = m_err;
      e.cyc   = cyc;
      sb.push_back(e);
    end
    for (int k = 1; k <= hold; k++) begin
      CLR = (k == clr_at);
      @(posedge CLOCK_50);
      #1;
    end
    CLR = 1'b0;
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  // Output monitor: every UPDATE must match the oldest expectation
  always @(negedge CLOCK_50) begin
    if (UPDATE) begin
      if (sb.size() == 0) begin
        check("spurious_update", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("upd_latency", cyc - e.cyc, STB + 2);
        check("digit",       int'(DIGIT), e.digit);
        check("digit_valid", int'(DIGIT_VALID), int'(e.dv));
        check("blank",       int'(BLANK), int'(e.bl));
        check("invalid",     int'(INVALID), int'(e.inv));
        check("upd_count",   int'(UPD_COUNT), e.upd);
        check("err_count",   int'(ERR_COUNT), e.err);
      end
    end
  end

  initial begin
    RESET_N = 1'b0;
    SEG_IN  = 7'b1111111;
    CLR     = 1'b0;
    model_reset();
    tick(3);
    check("rst_digit", int'(DIGIT), 0);
    check("rst_flags", int'({DIGIT_VALID, BLANK, INVALID, UPDATE}), 0);
    check("rst_upd",   int'(UPD_COUNT), 0);
    check("rst_err",   int'(ERR_COUNT), 0);

    // Release with blank held: first accept is the blank pattern
    RESET_N = 1'b1;
    drive_pat(7'b1111111, 12, 0);
    check("blank_locked", int'(BLANK), 1);

    drive_pat(7'b0010010, 8, 0);
    check("digit2", int'(DIGIT), 2);

    // Clear on an idle edge, then sweep all digits
    CLR = 1'b1;
    tick(1);
    CLR = 1'b0;
    m_upd = 0;
    m_err = 0;
    check("clr_idle", int'(UPD_COUNT), 0);
    for (int i = 0; i < 10; i++) drive_pat(codes[i], 8, 0);
    check("sweep_upd", int'(UPD_COUNT), 10);

    // Glitch rejection around a locked 2
    drive_pat(7'b0010010, 8, 0);
    drive_pat(7'b1001111, 2, 0);
    drive_pat(7'b0010010, 8, 0);
    check("glitch2_digit", int'(DIGIT), 2);
    check("glitch2_valid", int'(DIGIT_VALID), 1);
    check("glitch2_upd",   int'(UPD_COUNT), m_upd);
    drive_pat(7'b1001111, 3, 0);
    drive_pat(7'b0010010, 8, 0);

    // Invalid pattern: DIGIT holds
    drive_pat(7'b1110000, 8, 0);
    check("inv_flag",  int'(INVALID), 1);
    check("inv_digit", int'(DIGIT), 2);
    check("inv_err",   int'(ERR_COUNT), 1);

    // CLR on the accept edge wins over the increment
    drive_pat(7'b0100100, 8, STB + 2);
    check("clr_upd", int'(UPD_COUNT), 0);
    check("clr_err", int'(ERR_COUNT), 0);

    // Saturation of both counters
    for (int i = 0; i < 300; i++) begin
      drive_pat(7'b1110000, 7, 0);
      drive_pat(7'b0000001, 7, 0);
    end
    check("sat_upd", int'(UPD_COUNT), MAXC);
    check("sat_err", int'(ERR_COUNT), MAXC);

    // Reset in the middle of settling towards 3
    SEG_IN = 7'b0000110;
    tick(4);
    RESET_N = 1'b0;
    #1;
    check("mid_rst_digit", int'(DIGIT), 0);
    check("mid_rst_flags", int'({DIGIT_VALID, BLANK, INVALID, UPDATE}), 0);
    check("mid_rst_upd",   int'(UPD_COUNT), 0);
    check("mid_rst_err",   int'(ERR_COUNT), 0);
    tick(2);
    RESET_N = 1'b1;
    model_reset();
    drive_pat(7'b0000110, 10, 0);
    check("post_rst_digit", int'(DIGIT), 3);
    check("post_rst_upd",   int'(UPD_COUNT), 1);

    tick(4);
    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_reader.md
Name: seg7_reader

Overview:
- Reader end of the 7-segment display interface. Samples an active-low segment bus of the kind driven onto G_HEX outputs.
- Synchronises and stability-filters the bus, then decodes the accepted pattern back to a BCD digit, with blank and invalid flags.
- Counts accepted updates and invalid patterns.
- Sits on the board side of a display driver as a loopback monitor or checker.

Parameters:
- STABLE_CYCLES, 3: consecutive identical synchronised samples required to accept a pattern. Legal range 2..15.
- CNT_W, 8: width of UPD_COUNT and ERR_COUNT.

Ports:
- CLOCK_50  input  1  system clock; all logic on posedge.
- RESET_N  input  1  asynchronous, active-low reset.
- SEG_IN  input  [0:6]  segment bus, active-low, bit 0 = a … bit 6 = g. Asynchronous to CLOCK_50.
- CLR  input  1  synchronous clear of UPD_COUNT and ERR_COUNT only.
- DIGIT  output  4  decoded value 0..9 of the last accepted digit pattern.
- DIGIT_VALID  output  1  accepted pattern is a legal digit.
- BLANK  output  1  accepted pattern is 1111111 (all segments off).
- INVALID  output  1  accepted pattern is neither a digit nor blank.
- UPDATE  output  1  one-cycle pulse when a new pattern is accepted.
- UPD_COUNT  output  CNT_W  number of UPDATE pulses, saturating.
- ERR_COUNT  output  CNT_W  number of accepted invalid patterns, saturating.

Behaviour:
- Reset (RESET_N low, async, immediate):
  - sync1, sync2, cand and acc all set to 1111111; stab_cnt = 0; FSM = EMPTY.
  - DIGIT = 0, DIGIT_VALID = 0, BLANK = 0, INVALID = 0, UPDATE = 0, UPD_COUNT = 0, ERR_COUNT = 0.
  - Reset asserted mid-settling discards the candidate. No UPDATE is produced on release.
- Synchroniser: two-flop chain SEG_IN -> sync1 -> sync2, all 7 bits.
- Stability filter, evaluated every edge:
  - If sync2 != cand: cand <= sync2, stab_cnt <= 1.
  - Else if stab_cnt < STABLE_CYCLES: stab_cnt <= stab_cnt+1.
  - If stab_cnt+1 == STABLE_CYCLES in this branch, run accept check on this edge.
  - stab_cnt saturates at STABLE_CYCLES.
- Accept check: accept if FSM == EMPTY, or if cand != acc.
  - On accept: acc <= cand; decoded outputs update; UPDATE = 1 for exactly one cycle.
  - Re-stabilising on the pattern already in acc produces no UPDATE.
- FSM:
  - EMPTY: nothing accepted since reset. First accept goes to LOCKED, even if the pattern is blank.
  - LOCKED: cand == acc. A cand load with a different value goes to SETTLING.
  - SETTLING: cand != acc, counting. Accept goes to LOCKED. A cand reload back to acc's value goes to LOCKED with no UPDATE.
- Latency: SEG_IN changes between edges 0 and 1 and then holds.
  - sync2 is new after edge 2; cand loads at edge 3.
  - Accept registers at edge STABLE_CYCLES+2, i.e. edge 5 at the default.
- Glitch rejection: any sync2 run shorter than STABLE_CYCLES is never accepted. Outputs hold their previous values.
- Decode table (a..g, active-low):
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100
  - 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000, 9 = 0000100
- Digit accept: DIGIT = value, DIGIT_VALID = 1, BLANK = 0, INVALID = 0.
- Blank accept: BLANK = 1, DIGIT_VALID = 0, INVALID = 0; DIGIT holds its last value.
- Other accept: INVALID = 1, DIGIT_VALID = 0, BLANK = 0; DIGIT holds. ERR_COUNT +1 on the same edge.
- Exactly one of DIGIT_VALID, BLANK, INVALID is 1 after the first accept; all three are 0 before it.
- Counters: UPD_COUNT +1 per UPDATE; both counters saturate at 2^CNT_W-1, no wrap.
- CLR: sets both counters to 0 on that edge. If CLR coincides with an increment, CLR wins and the result is 0. CLR does not affect decode outputs or the FSM.

Test Plan:
- Reset release, SEG_IN held at 1111111 -> UPDATE at edge 5 after release; BLANK = 1, DIGIT_VALID = 0, UPD_COUNT = 1. No further UPDATE while SEG_IN holds.
- SEG_IN 1111111 -> 0010010 held -> accept exactly STABLE_CYCLES+2 edges later: DIGIT = 2, DIGIT_VALID = 1, UPDATE high for 1 cycle. Sweep all ten digit codes: DIGIT 0..9, UPD_COUNT = 10.
- With DIGIT = 2 locked, pulse SEG_IN to 1001111 for 2 cycles, then back -> no UPDATE, DIGIT stays 2, FSM returns to LOCKED. The same pulse held 3+ cycles -> DIGIT = 1, UPDATE.
- SEG_IN = 1110000 held -> INVALID = 1, DIGIT holds its previous value, ERR_COUNT = 1. Alternate 1110000 and 0000001, 300 times with CNT_W = 8 -> ERR_COUNT saturates at 255, UPD_COUNT saturates at 255.
- CLR asserted on the same edge as an UPDATE -> UPD_COUNT = 0 after that edge; DIGIT still updates.
- RESET_N pulsed low while SETTLING toward 0000110 -> all outputs 0 immediately. After release with 0000110 held, the first UPDATE comes at edge 5 with DIGIT = 3, UPD_COUNT = 1.
